// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, ROM addressing and a small fetch FIFO toward decode.
// Optional misaligned-redirect trap is enabled with `define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0,
    parameter int             DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    output logic [W-1:0]  imem_addr,
    input  logic [W-1:0]  imem_rdata,
    input  logic          redirect_valid,
    input  logic [W-1:0]  redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_instr,
    output logic [W-1:0]  out_pc,
    output logic [W-1:0]  out_pc_plus4,
    output logic          fetch_fault
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]      pc_q;
    logic [W-1:0]      pc_next_seq;
    logic [W-1:0]      target;
    logic              fault_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count_q;
    logic [W-1:0]      instr_mem [DEPTH];
    logic [W-1:0]      pc_mem    [DEPTH];
    logic              full;
    logic              pop;
    logic              push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Decode handshake: an entry transfers on a cycle where out_valid && out_ready;
    // out_* stay stable while out_valid && !out_ready, and out_valid never drops without a pop,
    // a redirect flush or reset.
    assign imem_addr   = pc_q;
    assign full        = (count_q == FULL);
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & out_ready;
    assign push        = fetch_en & ~redirect_valid & ~fault_q & (~full | pop);
    assign pc_next_seq = pc_q + W'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);
    // A misaligned target is kept as-is so the faulting address remains visible on imem_addr.
    assign target     = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= misaligned;
        end
    end
`else
    assign target  = redirect_pc & ~(W'(3));
    assign fault_q = 1'b0;
`endif

    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect_valid) begin
            // A same-cycle pop is already taken by decode; everything left is wrong-path.
            pc_q    <= target;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc_q   <= pc_next_seq;
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= pc_q;
        end
    end

    assign out_instr    = instr_mem[rd_ptr];
    assign out_pc       = pc_mem[rd_ptr];
    assign out_pc_plus4 = pc_mem[rd_ptr] + W'(4);

endmodule
